sad_min_tree: RTL and testbench

//   Parametrised pipelined SAD adder tree with best-candidate search.
//   - Sums NUM_IN absolute-difference values per cycle through a registered binary tree.
//   - Tracks the minimum SAD, and its candidate index, over a search of up to NCAND

---
 rtl/sad_min_tree_if.sv | 31 +++
 rtl/sad_min_tree.sv | 174 +++++++++++++++++
 tb/tb_sad_min_tree.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sad_min_tree_if.sv
// rtl/sad_min_tree_if.sv - AD vector input and SAD/best-candidate result bundle
interface sad_min_tree_if #(
  parameter int NUM_IN = 64,
  parameter int DW     = 8,
  parameter int NCAND  = 4
);
  localparam int LVL = $clog2(NUM_IN);
  localparam int SW  = DW + LVL;
  localparam int IW  = (NCAND > 1) ? $clog2(NCAND) : 1;

  logic [NUM_IN*DW-1:0] ad;
  logic                 in_valid;
  logic                 in_first;
  logic                 in_last;
  logic [SW-1:0]        sum;
  logic                 sum_valid;
  logic [SW-1:0]        best_sad;
  logic [IW-1:0]        best_idx;
  logic                 best_valid;
  logic                 err_ovf;

  modport master (
    output ad, in_valid, in_first, in_last,
    input  sum, sum_valid, best_sad, best_idx, best_valid, err_ovf
  );

  modport slave (
    input  ad, in_valid, in_first, in_last,
    output sum, sum_valid, best_sad, best_idx, best_valid, err_ovf
  );
endinterface

// File: rtl/sad_min_tree.sv
// rtl/sad_min_tree.sv - pipelined SAD adder tree with minimum-SAD candidate tracker
module sad_min_tree #(
  parameter int NUM_IN = 64,
  parameter int DW     = 8,
  parameter int NCAND  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sad_min_tree_if.slave  bus
);
  localparam int LVL = $clog2(NUM_IN);
  localparam int SW  = DW + LVL;
  localparam int IW  = (NCAND > 1) ? $clog2(NCAND) : 1;
  localparam int CW  = $clog2(NCAND + 1);
  localparam logic [CW-1:0] NCAND_C = CW'(NCAND);

  // Bit offset of tree level k inside the flat tr vector (level 0 = registered inputs).
  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int m = 0; m < k; m++) o += (NUM_IN >> m) * (DW + m);
    return o;
  endfunction

  localparam int TOT = lvl_off(LVL + 1);

  logic [NUM_IN*DW-1:0] ad_r;
  logic [LVL:0]         v_p;
  logic [LVL:0]         f_p;
  logic [LVL:0]         l_p;
  wire  [TOT-1:0]       tr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ad_r <= '0;
      v_p  <= '0;
      f_p  <= '0;
      l_p  <= '0;
    end else begin
      ad_r <= bus.ad;
      v_p  <= {v_p[LVL-1:0], bus.in_valid};
      f_p  <= {f_p[LVL-1:0], bus.in_valid & bus.in_first};
      l_p  <= {l_p[LVL-1:0], bus.in_valid & bus.in_last};
    end
  end

  assign tr[0 +: NUM_IN*DW] = ad_r;

  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int N    = NUM_IN >> k;
    localparam int W    = DW + k;
    localparam int OFF  = lvl_off(k);
    localparam int POFF = lvl_off(k - 1);
    logic [N*W-1:0] s;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s <= '0;
      end else begin
        for (int j = 0; j < N; j++) begin
          s[j*W +: W] <= {1'b0, tr[POFF + (2*j)*(W-1) +: W-1]}
                       + {1'b0, tr[POFF + (2*j+1)*(W-1) +: W-1]};
        end
      end
    end

    assign tr[OFF +: N*W] = s;
  end

  logic [SW-1:0] sum_w;
  logic          sv;
  logic          fo;
  logic          lo;

  assign sum_w = tr[lvl_off(LVL) +: SW];
  assign sv    = v_p[LVL];
  assign fo    = f_p[LVL];
  assign lo    = l_p[LVL];

  typedef enum logic {IDLE, SRCH} state_t;
  state_t state_q, state_d;

  logic [SW-1:0] cur_min;
  logic [IW-1:0] cur_idx;
  logic [CW-1:0] cnt;
  logic          err_r;
  logic [SW-1:0] best_sad_r;
  logic [IW-1:0] best_idx_r;
  logic          best_valid_r;

  logic          start;
  logic          take;
  logic          better;
  logic          ovf_hit;
  logic          fin;
  logic [SW-1:0] nxt_min;
  logic [IW-1:0] nxt_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sv && fo)                             state_d = lo ? IDLE : SRCH;
    else if (state_q == SRCH && sv && lo)     state_d = IDLE;
  end

  // Decisions for the candidate at the tree output; nxt_* already include it.
  always_comb begin
    start   = sv && fo;
    take    = 1'b0;
    better  = 1'b0;
    ovf_hit = 1'b0;
    fin     = 1'b0;
    nxt_min = cur_min;
    nxt_idx = cur_idx;
    if (state_q == SRCH && sv && !fo) begin
      if (cnt < NCAND_C) begin
        take   = 1'b1;
        better = (sum_w < cur_min);
      end else begin
        ovf_hit = 1'b1;
      end
    end
    if (start) begin
      nxt_min = sum_w;
      nxt_idx = '0;
    end else if (better) begin
      nxt_min = sum_w;
      nxt_idx = cnt[IW-1:0];
    end
    fin = sv && lo && (fo || state_q == SRCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_min      <= '0;
      cur_idx      <= '0;
      cnt          <= '0;
      err_r        <= 1'b0;
      best_sad_r   <= '0;
      best_idx_r   <= '0;
      best_valid_r <= 1'b0;
    end else begin
      if (start) begin
        cur_min <= sum_w;
        cur_idx <= '0;
        cnt     <= CW'(1);
        err_r   <= 1'b0;
      end else begin
        if (better) begin
          cur_min <= sum_w;
          cur_idx <= cnt[IW-1:0];
        end
        if (take)    cnt   <= cnt + CW'(1);
        if (ovf_hit) err_r <= 1'b1;
      end
      best_valid_r <= fin;
      if (fin) begin
        best_sad_r <= nxt_min;
        best_idx_r <= nxt_idx;
      end
    end
  end

  assign bus.sum        = sum_w;
  assign bus.sum_valid  = sv;
  assign bus.best_sad   = best_sad_r;
  assign bus.best_idx   = best_idx_r;
  assign bus.best_valid = best_valid_r;
  assign bus.err_ovf    = err_r;
endmodule

// File: tb/tb_sad_min_tree.sv
// tb/tb_sad_min_tree.sv - table-driven scoreboard bench for sad_min_tree
module tb_sad_min_tree;
  localparam int NUM_IN = 64;
  localparam int DW     = 8;
  localparam int NCAND  = 4;
  localparam int LVL    = 6;
  localparam int SW     = DW + LVL;
  localparam int IW     = 2;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;

  sad_min_tree_if #(.NUM_IN(NUM_IN), .DW(DW), .NCAND(NCAND)) bus ();

  sad_min_tree #(.NUM_IN(NUM_IN), .DW(DW), .NCAND(NCAND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          v, f, l;
    int            mode;
    int            val;
    logic [SW-1:0] esum;
    logic          eb;
    logic [SW-1:0] bsad;
    logic [IW-1:0] bidx;
    logic          bovf;
  } rec_t;

  typedef struct { logic [SW-1:0] s; int due; } sexp_t;
  typedef struct { logic [SW-1:0] sad; logic [IW-1:0] idx; logic ovf; int due; } bexp_t;

  sexp_t sum_q[$];
  bexp_t best_q[$];
  rec_t  tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rec_t mk(input logic v, input logic f, input logic l, input int mode,
                              input int val, input int esum, input logic eb,
                              input int bsad, input int bidx, input logic bovf);
    rec_t r;
    r.v = v; r.f = f; r.l = l; r.mode = mode; r.val = val;
    r.esum = SW'(esum); r.eb = eb; r.bsad = SW'(bsad); r.bidx = IW'(bidx); r.bovf = bovf;
    return r;
  endfunction

  // mode 1: ad[i]=i; otherwise spread val over the elements so they sum to val.
  function automatic logic [NUM_IN*DW-1:0] fill(input int mode, input int val);
    logic [NUM_IN*DW-1:0] a;
    int b;
    for (int i = 0; i < NUM_IN; i++) begin
      if (mode == 1) b = i;
      else           b = val / NUM_IN + ((i < val % NUM_IN) ? 1 : 0);
      a[i*DW +: DW] = DW'(b);
    end
    return a;
  endfunction

  task automatic drive(input rec_t r);
    sexp_t se;
    bexp_t be;
    bus.ad       = fill(r.mode, r.val);
    bus.in_valid = r.v;
    bus.in_first = r.f;
    bus.in_last  = r.l;
    if (r.v) begin
      se.s = r.esum; se.due = cyc + 1 + LVL;
      sum_q.push_back(se);
    end
    if (r.eb) begin
      be.sad = r.bsad; be.idx = r.bidx; be.ovf = r.bovf; be.due = cyc + 2 + LVL;
      best_q.push_back(be);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin : monitor
    sexp_t se;
    bexp_t be;
    if (rst_n) begin
      if (bus.sum_valid) begin
        if (sum_q.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL sum_unexpected: got sum_valid=1 sum=%0d expected sum_valid=0 (cycle %0d)", bus.sum, cyc);
        end else begin
          se = sum_q.pop_front();
          check("sum", 32'(bus.sum), 32'(se.s));
          check("sum_latency", cyc, se.due);
        end
      end else if (sum_q.size() > 0 && sum_q[0].due < cyc) begin
        se = sum_q.pop_front();
        check("sum_missing", 32'(0), 32'(1));
      end
      if (bus.best_valid) begin
        if (best_q.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL best_unexpected: got best_valid=1 best_sad=%0d expected best_valid=0 (cycle %0d)", bus.best_sad, cyc);
        end else begin
          be = best_q.pop_front();
          check("best_sad", 32'(bus.best_sad), 32'(be.sad));
          check("best_idx", 32'(bus.best_idx), 32'(be.idx));
          check("err_ovf_at_best", 32'(bus.err_ovf), 32'(be.ovf));
          check("best_latency", cyc, be.due);
        end
      end else if (best_q.size() > 0 && best_q[0].due < cyc) begin
        be = best_q.pop_front();
        check("best_missing", 32'(0), 32'(1));
      end
    end
  end

  initial begin
    logic [NUM_IN*DW-1:0] ra;
    int    model;
    sexp_t se;

    rst_n = 1'b0;
    bus.ad = '0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum_valid", 32'(bus.sum_valid), 0);
    check("rst_best_valid", 32'(bus.best_valid), 0);
    check("rst_err_ovf", 32'(bus.err_ovf), 0);
    check("rst_best_sad", 32'(bus.best_sad), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //          v f l mode val    esum  eb bsad bidx ovf
    tbl.push_back(mk(1,0,0,0,16320,16320,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,2016,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,64,64,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,900,900,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,300,300,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,300,300,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,500,500,1,300,1,0));
    tbl.push_back(mk(1,1,0,0,50,50,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,40,40,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,30,30,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,20,20,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,10,10,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,5,5,1,20,3,1));
    tbl.push_back(mk(1,1,1,0,42,42,1,42,0,0));
    tbl.push_back(mk(1,0,0,0,123,123,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,7,7,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,100,100,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,10,10,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,77,77,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,88,88,1,77,0,0));
    tbl.push_back(mk(1,1,1,0,5,5,1,5,0,0));
    tbl.push_back(mk(1,1,0,0,9,9,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,3,3,1,3,1,0));

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
    idle(1);

    // Random flagless vectors: sums from a software model, tracker stays idle.
    for (int n = 0; n < 16; n++) begin
      model = 0;
      for (int i = 0; i < NUM_IN; i++) begin
        ra[i*DW +: DW] = DW'($urandom_range(0, 255));
        model += int'(ra[i*DW +: DW]);
      end
      bus.ad = ra; bus.in_valid = 1'b1; bus.in_first = 1'b0; bus.in_last = 1'b0;
      se.s = SW'(model); se.due = cyc + 1 + LVL;
      sum_q.push_back(se);
      @(posedge clk); #1;
    end
    idle(12);

    // Reset three cycles into a search: nothing from it may surface.
    bus.ad = fill(0, 400); bus.in_valid = 1'b1; bus.in_first = 1'b1; bus.in_last = 1'b0;
    @(posedge clk); #1;
    bus.in_first = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_sum", 32'(bus.sum), 0);
    check("midrst_sum_valid", 32'(bus.sum_valid), 0);
    check("midrst_best_sad", 32'(bus.best_sad), 0);
    check("midrst_best_idx", 32'(bus.best_idx), 0);
    check("midrst_best_valid", 32'(bus.best_valid), 0);
    sum_q.delete();
    best_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(12);

    drive(mk(1,1,0,0,70,70,0,0,0,0));
    drive(mk(1,0,0,0,60,60,0,0,0,0));
    drive(mk(1,0,1,0,80,80,1,60,1,0));
    idle(14);

    check("sum_queue_drained", sum_q.size(), 0);
    check("best_queue_drained", best_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
